// File: rtl/wb_stage_pkg.sv
// -----------------------------------------------------------------------------
// wb_stage_pkg
// Shared definitions for the writeback stage: bus widths that must line up
// with the register file, the load funct3 encodings, and the FSM states.
// -----------------------------------------------------------------------------
package wb_stage_pkg;

  // Widths of the register-file data bus, address bus and retire counter.
  localparam int unsigned WB_XLEN   = 32;
  localparam int unsigned WB_REG_AW = 5;
  localparam int unsigned WB_CNT_W  = 64;

  // Load funct3 encodings.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,  // nothing in flight
    ST_WRITE     = 2'b01,  // write port holds a completed result
    ST_WAIT_LOAD = 2'b10   // load accepted, waiting for dmem data
  } wb_state_e;

endpackage

// File: rtl/wb_stage_load_extend.sv
// -----------------------------------------------------------------------------
// wb_stage_load_extend
// Combinational sub-word load extraction and sign/zero extension.
// Ports:
//   rdata_i   - raw aligned word from data memory
//   funct3_i  - load type (LB/LH/LW/LBU/LHU; others pass the word)
//   addr_lo_i - low two bits of the load effective address
//   result_o  - extended value for the register file
// -----------------------------------------------------------------------------
module wb_stage_load_extend
  import wb_stage_pkg::*;
#(
  parameter int unsigned XLEN = WB_XLEN
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  output logic [XLEN-1:0] result_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign byte_s = rdata_i[{addr_lo_i, 3'b000} +: 8];
  // addr_lo_i[0] is ignored for halves: misaligned halves trap upstream.
  assign half_s = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

  // Select and extend the addressed byte/half according to the load type.
  always_comb begin
    result_o = rdata_i;
    case (funct3_i)
      F3_LB:   result_o = {{(XLEN-8){byte_s[7]}}, byte_s};
      F3_LH:   result_o = {{(XLEN-16){half_s[15]}}, half_s};
      F3_LW:   result_o = rdata_i;
      F3_LBU:  result_o = {{(XLEN-8){1'b0}}, byte_s};
      F3_LHU:  result_o = {{(XLEN-16){1'b0}}, half_s};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
// Writeback stage between MEM and the register file. Accepts one retiring
// instruction per handshake, waits for load data when needed, and drives the
// register-file write port from registers. Also counts retired instructions.
// Ports:
//   clk, rst                - clock; asynchronous active-low reset
//   mem_valid / mem_ready   - retire handshake from the MEM stage
//   mem_rd_we, mem_rd_addr  - destination register write enable / address
//   mem_alu_result          - result for non-load instructions
//   mem_is_load, mem_funct3, mem_addr_lo - load descriptor
//   dmem_rvalid, dmem_rdata - load data return from data memory
//   we, waddr, wdata        - registered register-file write port
//   instret                 - retired-instruction counter
// -----------------------------------------------------------------------------
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned XLEN   = WB_XLEN,
  parameter int unsigned REG_AW = WB_REG_AW,
  parameter int unsigned CNT_W  = WB_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic              mem_rd_we,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic [XLEN-1:0]   mem_alu_result,
  input  logic              mem_is_load,
  input  logic [2:0]        mem_funct3,
  input  logic [1:0]        mem_addr_lo,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              we,
  output logic [REG_AW-1:0] waddr,
  output logic [XLEN-1:0]   wdata,
  output logic [CNT_W-1:0]  instret
);

  wb_state_e         state_q;
  logic              we_q;
  logic [REG_AW-1:0] waddr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [REG_AW-1:0] rd_addr_q;
  logic              rd_we_q;
  logic [2:0]        funct3_q;
  logic [1:0]        addr_lo_q;
  logic [CNT_W-1:0]  instret_q;
  logic [CNT_W-1:0]  instret_d;

  logic              accept_s;
  logic              mem_rd_nz_s;
  logic              cap_rd_nz_s;
  logic [XLEN-1:0]   ext_s;

  // Gating with rst keeps ready low for the whole reset assertion.
  assign mem_ready   = rst && (state_q != ST_WAIT_LOAD);
  assign accept_s    = mem_valid && mem_ready;
  assign mem_rd_nz_s = (mem_rd_addr != {REG_AW{1'b0}});
  assign cap_rd_nz_s = (rd_addr_q != {REG_AW{1'b0}});

  wb_stage_load_extend #(
    .XLEN (XLEN)
  ) u_load_extend (
    .rdata_i   (dmem_rdata),
    .funct3_i  (funct3_q),
    .addr_lo_i (addr_lo_q),
    .result_o  (ext_s)
  );

  // Writeback FSM with registered write-port outputs and load capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      waddr_q   <= {REG_AW{1'b0}};
      wdata_q   <= {XLEN{1'b0}};
      rd_addr_q <= {REG_AW{1'b0}};
      rd_we_q   <= 1'b0;
      funct3_q  <= 3'b000;
      addr_lo_q <= 2'b00;
    end else begin
      case (state_q)
        ST_IDLE, ST_WRITE: begin
          if (accept_s) begin
            if (mem_is_load) begin
              state_q   <= ST_WAIT_LOAD;
              rd_addr_q <= mem_rd_addr;
              rd_we_q   <= mem_rd_we;
              funct3_q  <= mem_funct3;
              addr_lo_q <= mem_addr_lo;
              we_q      <= 1'b0;
            end else begin
              state_q <= ST_WRITE;
              wdata_q <= mem_alu_result;
              waddr_q <= mem_rd_addr;
              // x0 is never written, but the instruction still retires.
              we_q    <= mem_rd_we && mem_rd_nz_s;
            end
          end else begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
          end
        end
        ST_WAIT_LOAD: begin
          if (dmem_rvalid) begin
            state_q <= ST_WRITE;
            wdata_q <= ext_s;
            waddr_q <= rd_addr_q;
            we_q    <= rd_we_q && cap_rd_nz_s;
          end else begin
            state_q <= ST_WAIT_LOAD;
            we_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

  // Every cycle spent in WRITE is exactly one retired instruction.
  always_comb begin
    if (state_q == ST_WRITE) begin
      instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      instret_d = instret_q;
    end
  end

  // Retired-instruction counter register; wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instret_q <= {CNT_W{1'b0}};
    end else begin
      instret_q <= instret_d;
    end
  end

  assign we      = we_q;
  assign waddr   = waddr_q;
  assign wdata   = wdata_q;
  assign instret = instret_q;

endmodule
